// File: rtl/branch_predictor.sv
// Dynamic branch predictor: tagged BTB plus a PHT of saturating counters, with
// same-cycle mispredict/redirect. Define BP_GSHARE_EN to XOR global history into the PHT index.
module branch_predictor #(
    parameter  int ENTRIES = 16,
    parameter  int CTR_W   = 2,
    parameter  int GHR_W   = 4,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_all,
    input  logic [31:0]      if_pc,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    output logic [IDX_W-1:0] pred_pht_idx,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic [IDX_W-1:0] upd_pht_idx,
    input  logic             upd_taken,
    input  logic [31:0]      upd_target,
    input  logic             upd_pred_taken,
    input  logic [31:0]      upd_pred_target,
    output logic             mispredict,
    output logic [31:0]      redirect_pc
);

    localparam int TAG_W = 30 - IDX_W;
    localparam logic [CTR_W-1:0] CTR_MAX     = '1;
    localparam logic [CTR_W-1:0] CTR_WEAK_T  = CTR_W'(2 ** (CTR_W - 1));
    localparam logic [CTR_W-1:0] CTR_WEAK_NT = CTR_W'(2 ** (CTR_W - 1) - 1);

    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] if_tag;
    logic [TAG_W-1:0] upd_tag;
    logic [IDX_W-1:0] ghr_ext;

    logic [ENTRIES-1:0] valid_vec;
    logic [CTR_W-1:0]   pht_arr    [ENTRIES];
    logic [TAG_W-1:0]   tag_mem    [ENTRIES];
    logic [31:0]        target_mem [ENTRIES];

    logic             upd_accept;
    logic             upd_hit;
    logic             btb_write;
    logic             if_hit;
    logic [CTR_W-1:0] pht_cur;
    logic [CTR_W-1:0] pht_next;
    logic             unused_pc_bits;

    // Byte-offset bits never participate: fetch is word aligned.
    assign unused_pc_bits = ^{if_pc[1:0], upd_pc[1:0]};

    assign if_idx  = if_pc[IDX_W+1:2];
    assign if_tag  = if_pc[31:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[31:IDX_W+2];

    assign upd_accept = upd_valid && !flush_all;
    assign upd_hit    = valid_vec[upd_idx] && (tag_mem[upd_idx] == upd_tag);
    assign btb_write  = upd_accept && upd_taken;
    assign pht_cur    = pht_arr[upd_pht_idx];

    // A taken branch that misses the BTB restarts its counter at weakly taken.
    always_comb begin
        pht_next = pht_cur;
        if (upd_taken && !upd_hit) begin
            pht_next = CTR_WEAK_T;
        end else if (upd_taken) begin
            if (pht_cur != CTR_MAX) pht_next = pht_cur + 1'b1;
        end else begin
            if (pht_cur != '0) pht_next = pht_cur - 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic             valid_reg;
            logic [CTR_W-1:0] pht_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    valid_reg <= 1'b0;
                    pht_reg   <= CTR_WEAK_NT;
                end else begin
                    if (flush_all)
                        valid_reg <= 1'b0;
                    else if (btb_write && upd_idx == IDX_W'(gi))
                        valid_reg <= 1'b1;
                    if (upd_accept && upd_pht_idx == IDX_W'(gi))
                        pht_reg <= pht_next;
                end
            end

            assign valid_vec[gi] = valid_reg;
            assign pht_arr[gi]   = pht_reg;
        end
    endgenerate

    // Tag/target need no reset: the valid bits gate every use of them.
    always_ff @(posedge clk) begin
        if (btb_write) begin
            tag_mem[upd_idx]    <= upd_tag;
            target_mem[upd_idx] <= upd_target;
        end
    end

`ifdef BP_GSHARE_EN
    logic [GHR_W-1:0] ghr_reg;
    logic [GHR_W-1:0] ghr_next;

    generate
        if (GHR_W > 1) begin : g_ghr_shift
            assign ghr_next = {ghr_reg[GHR_W-2:0], upd_taken};
        end else begin : g_ghr_bit
            assign ghr_next = upd_taken;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            ghr_reg <= '0;
        else if (flush_all)
            ghr_reg <= '0;
        else if (upd_accept)
            ghr_reg <= ghr_next;
    end

    always_comb begin
        ghr_ext = '0;
        ghr_ext[GHR_W-1:0] = ghr_reg;
    end
`else
    assign ghr_ext = '0;
`endif

    assign if_hit       = valid_vec[if_idx] && (tag_mem[if_idx] == if_tag);
    assign pred_pht_idx = if_idx ^ ghr_ext;
    assign pred_taken   = if_hit && pht_arr[pred_pht_idx][CTR_W-1];
    assign pred_target  = pred_taken ? target_mem[if_idx] : if_pc + 32'd4;

    assign mispredict  = upd_valid && ((upd_taken != upd_pred_taken) ||
                                       (upd_taken && (upd_target != upd_pred_target)));
    assign redirect_pc = upd_taken ? upd_target : upd_pc + 32'd4;

endmodule
